// File: rtl/gpu_pkg.sv
// Shared definitions for the raycaster GPU: pixel classes, scheduler states,
// default screen geometry and small helpers used by the column scheduler.
package gpu_pkg;

  localparam int DEFAULT_SCREEN_WIDTH     = 640;
  localparam int DEFAULT_SCREEN_HEIGHT_PX = 480;
  localparam int DEFAULT_TEXTURE_SIZE     = 64;

  // Screen coordinates and distances travel on fixed-width buses.
  localparam int COORD_W = 10;
  localparam int DIST_W  = 16;

  // Pixel classification codes; 2'b11 is never produced.
  localparam logic [1:0] PIX_CEIL  = 2'b00;
  localparam logic [1:0] PIX_WALL  = 2'b01;
  localparam logic [1:0] PIX_FLOOR = 2'b10;

  // Smallest distance handed to the lookup; a zero distance would make the
  // projected wall height blow up, so it is replaced by one LSB of Q8.8.
  localparam logic [DIST_W-1:0] MIN_DISTANCE = 16'h0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } sched_state_e;

  // Wall wins over ceiling, anything that is neither is floor.
  function automatic logic [1:0] classify_pixel(input logic inside_wall,
                                                input logic above_wall);
    if (inside_wall) return PIX_WALL;
    if (above_wall)  return PIX_CEIL;
    return PIX_FLOOR;
  endfunction

  function automatic logic [DIST_W-1:0] clamp_distance(input logic [DIST_W-1:0] d);
    return (d == '0) ? MIN_DISTANCE : d;
  endfunction

endpackage

// File: rtl/gpu_column_scheduler.sv
// Frame sequencer for the wall renderer. Walks the screen column by column,
// fetches each column's wall distance and texture u, then sweeps screen_y
// through the external lookup and streams one classified pixel per cycle.
module gpu_column_scheduler
  import gpu_pkg::*;
#(
  parameter int SCREEN_WIDTH     = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT_PX = DEFAULT_SCREEN_HEIGHT_PX,
  parameter int TEXTURE_SIZE     = DEFAULT_TEXTURE_SIZE,
  localparam int UVW             = $clog2(TEXTURE_SIZE)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  output logic               busy,
  output logic               frame_done,
  output logic               dist_req,
  output logic [COORD_W-1:0] dist_addr,
  input  logic               dist_valid,
  input  logic [DIST_W-1:0]  dist_data,
  input  logic [UVW-1:0]     dist_uv_x,
  output logic [DIST_W-1:0]  lk_distance,
  output logic [COORD_W-1:0] lk_screen_y,
  input  logic [UVW-1:0]     lk_uv_y,
  input  logic               lk_inside_wall,
  input  logic               lk_above_wall,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [1:0]         pix_class,
  output logic [UVW-1:0]     pix_uv_x,
  output logic [UVW-1:0]     pix_uv_y
);

  // Terminal counter values; both dimensions are limited to 1024 so the
  // 10-bit counters never wrap and exact compares are sufficient.
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_HEIGHT_PX - 1);

  sched_state_e       state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               dist_req_q, dist_req_d;
  logic [DIST_W-1:0]  dist_q, dist_d;
  logic [UVW-1:0]     col_uv_q, col_uv_d;
  logic               pix_valid_q, pix_valid_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d;
  logic [COORD_W-1:0] pix_y_q, pix_y_d;
  logic [1:0]         pix_class_q, pix_class_d;
  logic [UVW-1:0]     pix_uv_x_q, pix_uv_x_d;
  logic [UVW-1:0]     pix_uv_y_q, pix_uv_y_d;
  logic               slot_free;

  // Output register can take a new pixel when it is empty or being drained.
  assign slot_free = !pix_valid_q || pix_ready;

  // Next-state logic for the frame walk, the column fetch and the pixel slot.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    dist_req_d   = dist_req_q;
    dist_d       = dist_q;
    col_uv_d     = col_uv_q;
    pix_valid_d  = pix_valid_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_class_d  = pix_class_q;
    pix_uv_x_d   = pix_uv_x_q;
    pix_uv_y_d   = pix_uv_y_q;

    case (state_q)
      IDLE: begin
        // busy is still high during the frame_done cycle, so a start pulse
        // arriving then is dropped and busy falls afterwards.
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (frame_start) begin
          state_d    = FETCH;
          x_d        = '0;
          y_d        = '0;
          busy_d     = 1'b1;
          dist_req_d = 1'b1;
        end
      end

      FETCH: begin
        // The last pixel of the previous column may still be waiting.
        if (pix_ready) begin
          pix_valid_d = 1'b0;
        end
        if (dist_valid) begin
          dist_d     = clamp_distance(dist_data);
          col_uv_d   = dist_uv_x;
          dist_req_d = 1'b0;
          y_d        = '0;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        if (slot_free) begin
          pix_valid_d = 1'b1;
          pix_x_d     = x_q;
          pix_y_d     = y_q;
          pix_class_d = classify_pixel(lk_inside_wall, lk_above_wall);
          pix_uv_x_d  = col_uv_q;
          pix_uv_y_d  = lk_uv_y;
          if (y_q == Y_LAST) begin
            if (x_q == X_LAST) begin
              state_d = DRAIN;
            end else begin
              x_d        = x_q + 10'd1;
              dist_req_d = 1'b1;
              state_d    = FETCH;
            end
          end else begin
            y_d = y_q + 10'd1;
          end
        end
      end

      DRAIN: begin
        if (slot_free) begin
          pix_valid_d  = 1'b0;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dist_req_q   <= 1'b0;
      dist_q       <= '0;
      col_uv_q     <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_class_q  <= PIX_CEIL;
      pix_uv_x_q   <= '0;
      pix_uv_y_q   <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      dist_req_q   <= dist_req_d;
      dist_q       <= dist_d;
      col_uv_q     <= col_uv_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_class_q  <= pix_class_d;
      pix_uv_x_q   <= pix_uv_x_d;
      pix_uv_y_q   <= pix_uv_y_d;
    end
  end

  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign dist_req    = dist_req_q;
  assign dist_addr   = x_q;
  assign lk_distance = dist_q;
  assign lk_screen_y = y_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_class   = pix_class_q;
  assign pix_uv_x    = pix_uv_x_q;
  assign pix_uv_y    = pix_uv_y_q;

endmodule

// File: tb/tb_gpu_column_scheduler.sv
// Bench for gpu_column_scheduler on a 4x8 screen with a behavioural lookup,
// a column-buffer responder and a scoreboard of expected pixels.
module tb_gpu_column_scheduler;

  localparam int W   = 4;
  localparam int H   = 8;
  localparam int TS  = 64;
  localparam int UVW = 6;

  typedef struct {
    int x;
    int y;
    int cls;
    int uvx;
    int uvy;
  } pix_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             frame_start = 1'b0;
  logic             busy, frame_done, dist_req;
  logic [9:0]       dist_addr;
  logic             dist_valid;
  logic [15:0]      dist_data;
  logic [UVW-1:0]   dist_uv_x;
  logic [15:0]      lk_distance;
  logic [9:0]       lk_screen_y;
  logic [UVW-1:0]   lk_uv_y;
  logic             lk_inside_wall, lk_above_wall;
  logic             pix_valid;
  logic             pix_ready;
  logic [9:0]       pix_x, pix_y;
  logic [1:0]       pix_class;
  logic [UVW-1:0]   pix_uv_x, pix_uv_y;

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;

  // Stimulus configuration, written only by the main process.
  int          cb_latency   = 1;
  bit          cb_en        = 1'b0;
  bit          ready_random = 1'b0;
  bit          mon_en       = 1'b0;
  bit          zero_check   = 1'b0;
  int          frame_id     = 0;
  int          spurious_req = 0;
  logic [15:0] col_dist [W];
  logic [5:0]  col_uv   [W];

  // Scoreboard and monitor state.
  pix_t        exp_q[$];
  pix_t        e;
  int          accept_count = 0;
  int          done_count   = 0;
  int          last_accept  = -10;
  bit          held         = 1'b0;
  logic [33:0] held_bundle;

  gpu_column_scheduler #(
    .SCREEN_WIDTH     (W),
    .SCREEN_HEIGHT_PX (H),
    .TEXTURE_SIZE     (TS)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_start    (frame_start),
    .busy           (busy),
    .frame_done     (frame_done),
    .dist_req       (dist_req),
    .dist_addr      (dist_addr),
    .dist_valid     (dist_valid),
    .dist_data      (dist_data),
    .dist_uv_x      (dist_uv_x),
    .lk_distance    (lk_distance),
    .lk_screen_y    (lk_screen_y),
    .lk_uv_y        (lk_uv_y),
    .lk_inside_wall (lk_inside_wall),
    .lk_above_wall  (lk_above_wall),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_class      (pix_class),
    .pix_uv_x       (pix_uv_x),
    .pix_uv_y       (pix_uv_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural lookup: wall half-height shrinks with distance around row H/2.
  function automatic int wall_half(input logic [15:0] d);
    if (d == 16'h0000) return 0;
    if (d < 16'h0080)  return 4;
    if (d < 16'h0100)  return 2;
    return 1;
  endfunction

  function automatic bit model_inside(input logic [15:0] d, input int y);
    int h;
    h = wall_half(d);
    return (y >= H/2 - h) && (y < H/2 + h);
  endfunction

  function automatic int model_class(input logic [15:0] d, input int y);
    if (model_inside(d, y)) return 1;
    if (y < H/2) return 0;
    return 2;
  endfunction

  function automatic logic [5:0] model_uv(input logic [15:0] d, input int y);
    int v;
    v = y * 3 + int'(d[3:0]) + int'(d[11:8]);
    return 6'(v);
  endfunction

  assign lk_inside_wall = model_inside(lk_distance, int'(lk_screen_y));
  assign lk_above_wall  = (int'(lk_screen_y) < H/2);
  assign lk_uv_y        = model_uv(lk_distance, int'(lk_screen_y));

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic pushColumn(input int c, input logic [15:0] d, input logic [5:0] uv);
    pix_t p;
    logic [15:0] eff;
    eff = (d == 16'h0000) ? 16'h0001 : d;
    for (int y = 0; y < H; y++) begin
      p.x   = c;
      p.y   = y;
      p.cls = model_class(eff, y);
      p.uvx = int'(uv);
      p.uvy = int'(model_uv(eff, y));
      exp_q.push_back(p);
    end
  endtask

  // Pseudo-random or constant downstream ready, changed just after each edge.
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Column buffer responder with configurable latency; also injects stray
  // dist_valid pulses on request while no fetch is pending.
  initial begin
    int cb_col;
    int seen_frame;
    int spurious_done;
    cb_col = 0;
    seen_frame = 0;
    spurious_done = 0;
    dist_valid = 1'b0;
    dist_data  = '0;
    dist_uv_x  = '0;
    forever begin
      @(negedge clk);
      if (seen_frame != frame_id) begin
        seen_frame = frame_id;
        cb_col = 0;
      end
      if (cb_en && dist_req) begin
        checkOutput("dist_addr", 64'(dist_addr), 64'(cb_col));
        for (int i = 1; i < cb_latency; i++) begin
          @(negedge clk);
          checkOutput("dist_req_hold", 64'(dist_req), 64'd1);
          checkOutput("dist_addr_hold", 64'(dist_addr), 64'(cb_col));
        end
        if (cb_col >= W) begin
          checkOutput("extra_fetch", 64'(cb_col), 64'(W - 1));
          cb_col = W - 1;
        end
        dist_data  = col_dist[cb_col];
        dist_uv_x  = col_uv[cb_col];
        dist_valid = 1'b1;
        pushColumn(cb_col, col_dist[cb_col], col_uv[cb_col]);
        @(negedge clk);
        dist_valid = 1'b0;
        cb_col++;
      end else if (spurious_req != spurious_done && !dist_req) begin
        spurious_done = spurious_req;
        dist_data  = 16'hFFFF;
        dist_uv_x  = 6'd63;
        dist_valid = 1'b1;
        @(negedge clk);
        dist_valid = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on every accept, hold-stability of a stalled
  // pixel, frame_done timing and the clamped distance during column 2.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        held = 1'b0;
        exp_q.delete();
      end else begin
        if (held) begin
          checkOutput("valid_held", 64'(pix_valid), 64'd1);
          checkOutput("pix_stable", 64'({pix_x, pix_y, pix_class, pix_uv_x, pix_uv_y}),
                      64'(held_bundle));
        end
        held = pix_valid && !pix_ready;
        held_bundle = {pix_x, pix_y, pix_class, pix_uv_x, pix_uv_y};
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("extra_pixel", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("pix_x", 64'(pix_x), 64'(e.x));
            checkOutput("pix_y", 64'(pix_y), 64'(e.y));
            checkOutput("pix_class", 64'(pix_class), 64'(e.cls));
            if (e.cls == 1) begin
              checkOutput("pix_uv_x", 64'(pix_uv_x), 64'(e.uvx));
              checkOutput("pix_uv_y", 64'(pix_uv_y), 64'(e.uvy));
            end
          end
          accept_count++;
          last_accept = cycle;
        end
        if (frame_done) begin
          done_count++;
          checkOutput("done_timing", 64'(cycle), 64'(last_accept + 1));
        end
        if (zero_check && busy && !dist_req && dist_addr == 10'd2) begin
          checkOutput("lk_distance_clamp", 64'(lk_distance), 64'h0001);
        end
      end
    end
  end

  task automatic setColumns(input bit zero_col2);
    for (int c = 0; c < W; c++) begin
      col_dist[c] = (zero_col2 && c == 2) ? 16'h0000 : 16'h0080;
      col_uv[c]   = 6'd5;
    end
  endtask

  task automatic waitInScan(input int col);
    int n;
    n = 0;
    while (!(pix_valid && !dist_req && busy && dist_addr == 10'(col)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkOutput("scan_timeout", 64'd0, 64'd1);
  endtask

  // Runs one full frame with the given column latency and disturbances.
  task automatic applyStimulus(input int latency, input bit rnd_ready, input bit zero_col2,
                               input bit disturb, input bit start_on_done);
    int n;
    int acc0;
    int done0;
    cb_latency   = latency;
    ready_random = rnd_ready;
    zero_check   = zero_col2;
    setColumns(zero_col2);
    frame_id++;
    cb_en  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    acc0  = accept_count;
    done0 = done_count;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    if (disturb) begin
      waitInScan(1);
      frame_start  = 1'b1;
      spurious_req = spurious_req + 1;
      @(negedge clk);
      frame_start = 1'b0;
    end
    n = 0;
    while (!frame_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) begin
      checkOutput("frame_timeout", 64'd0, 64'd1);
    end else if (start_on_done) begin
      checkOutput("busy_at_done", 64'(busy), 64'd1);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      checkOutput("restart_ignored", 64'(busy), 64'd0);
    end
    repeat (4) @(negedge clk);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_dist_req", 64'(dist_req), 64'd0);
    checkOutput("idle_pix_valid", 64'(pix_valid), 64'd0);
    checkOutput("pixel_count", 64'(accept_count - acc0), 64'(W * H));
    checkOutput("done_count", 64'(done_count - done0), 64'd1);
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    ready_random = 1'b0;
    zero_check   = 1'b0;
  endtask

  initial begin
    setColumns(1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    $display("[TB] reset idle check");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("reset_ctrl", 64'({busy, frame_done, dist_req, pix_valid, dist_addr, lk_distance}), 64'd0);
      checkOutput("reset_pix", 64'({lk_screen_y, pix_x, pix_y, pix_class, pix_uv_x, pix_uv_y}), 64'd0);
    end

    $display("[TB] frame, latency 1, ready high");
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("[TB] frame, latency 7");
    applyStimulus(7, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] frame, random ready");
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("[TB] frame, stray frame_start and dist_valid in scan");
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("[TB] frame, zero distance on column 2");
    applyStimulus(3, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset in the middle of a scan");
    cb_latency = 1;
    setColumns(1'b0);
    frame_id++;
    mon_en = 1'b1;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    waitInScan(1);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_pix_valid", 64'(pix_valid), 64'd0);
    checkOutput("midreset_dist_req", 64'(dist_req), 64'd0);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("postreset_busy", 64'(busy), 64'd0);
    checkOutput("postreset_dist_req", 64'(dist_req), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Absolute time bound in case the DUT stalls somewhere unforeseen.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d failures %0d", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
